// File: rtl/da_lut_builder.sv
// da_lut_builder: loads TAPS signed coefficients over a valid/ready stream,
// then writes all 2^TAPS distributed-arithmetic partial sums, one per clock,
// in Gray-code address order so each word is one add/subtract away from
// the previous one.
// Optional feature macro: DA_LUT_CHECKSUM_EN adds a 24-bit running checksum
// of every written word.
module da_lut_builder #(
  parameter int TAPS = 7,
  parameter int CW   = 12,
  parameter int OW   = 17
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 coef_valid,
  output logic                 coef_ready,
  input  logic signed [CW-1:0] coef_data,
  output logic                 wr_en,
  output logic [TAPS-1:0]      wr_addr,
  output logic [OW-1:0]        wr_data,
  output logic                 busy,
  output logic                 done
`ifdef DA_LUT_CHECKSUM_EN
  ,
  output logic [23:0]          checksum
`endif
);

  localparam int CNT_W = (TAPS > 1) ? $clog2(TAPS) : 1;

  typedef enum logic [1:0] {LOAD, BUILD, DONE} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q;
  logic [TAPS-1:0][CW-1:0] coef_q;
  logic [TAPS-1:0]         k_q, k_nxt, g_nxt;
  logic [OW-1:0]           acc_q, acc_nxt, delta;
  logic                    accept, last_beat, last_step, found;

  // Next-state decode plus handshake/status outputs, all derived from state.
  always_comb begin
    state_d    = state_q;
    coef_ready = 1'b0;
    busy       = 1'b0;
    accept     = 1'b0;
    last_beat  = 1'b0;
    last_step  = 1'b0;
    case (state_q)
      LOAD: begin
        coef_ready = 1'b1;
        accept     = coef_valid;
        last_beat  = coef_valid && (cnt_q == CNT_W'(TAPS - 1));
        if (last_beat) state_d = BUILD;
      end
      BUILD: begin
        busy      = 1'b1;
        last_step = (k_q == '1);
        if (last_step) state_d = DONE;
      end
      DONE: begin
        busy    = 1'b1;
        state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  // Gray step: the lowest set bit of k+1 is the single address bit that
  // flips; add its coefficient if the bit turns on, subtract if it turns off.
  always_comb begin
    k_nxt = k_q + TAPS'(1);
    g_nxt = k_nxt ^ (k_nxt >> 1);
    delta = '0;
    found = 1'b0;
    for (int i = 0; i < TAPS; i++) begin
      if (k_nxt[i] && !found) begin
        found = 1'b1;
        delta = {{(OW-CW){coef_q[i][CW-1]}}, coef_q[i]};
        if (!g_nxt[i]) delta = -delta;
      end
    end
    acc_nxt = acc_q + delta;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= LOAD;
    else     state_q <= state_d;
  end

  // Coefficient capture, step counter/accumulator and registered write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      coef_q  <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        LOAD: begin
          if (accept) begin
            coef_q[cnt_q] <= coef_data;
            if (last_beat) begin
              // Step 0 (address 0, data 0) goes out on the next cycle.
              cnt_q   <= '0;
              k_q     <= '0;
              acc_q   <= '0;
              wr_en   <= 1'b1;
              wr_addr <= '0;
              wr_data <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        BUILD: begin
          if (last_step) begin
            wr_en <= 1'b0;
            done  <= 1'b1;
          end else begin
            k_q     <= k_nxt;
            acc_q   <= acc_nxt;
            wr_addr <= g_nxt;
            wr_data <= acc_nxt;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DA_LUT_CHECKSUM_EN
  logic [23:0] csum_q;

  // Running sum of written words; cleared as the build starts, then frozen
  // from done until the next build.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            csum_q <= '0;
    else if (last_beat) csum_q <= '0;
    else if (wr_en)     csum_q <= csum_q + {{(24-OW){wr_data[OW-1]}}, wr_data};
  end

  assign checksum = csum_q;
`endif

endmodule

// File: tb/tb_da_lut_builder.sv
// Self-checking bench for da_lut_builder: directed and random coefficient
// sets, valid gaps, junk valid during the build, and an async reset mid-build.
module tb_da_lut_builder;
  localparam int TAPS = 7;
  localparam int CW   = 12;
  localparam int OW   = 17;
  localparam int N    = 1 << TAPS;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 coef_valid = 1'b0;
  logic signed [CW-1:0] coef_data = '0;
  logic                 coef_ready, wr_en, busy, done;
  logic [TAPS-1:0]      wr_addr;
  logic [OW-1:0]        wr_data;
`ifdef DA_LUT_CHECKSUM_EN
  logic [23:0]          checksum;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cf[TAPS];

  da_lut_builder #(.TAPS(TAPS), .CW(CW), .OW(OW)) dut (
    .clk(clk), .rst(rst), .coef_valid(coef_valid), .coef_ready(coef_ready),
    .coef_data(coef_data), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done)
`ifdef DA_LUT_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Table word straight from the definition: sum of coef[j] over set bits j.
  function automatic logic [OW-1:0] ref_word(input int addr);
    int s = 0;
    for (int j = 0; j < TAPS; j++)
      if (((addr >> j) & 1) == 1) s += cf[j];
    return s[OW-1:0];
  endfunction

  function automatic logic [23:0] ref_csum();
    int s = 0;
    for (int j = 0; j < TAPS; j++) s += cf[j];
    s = s * (1 << (TAPS - 1));
    return s[23:0];
  endfunction

  // Feed cf[] as TAPS beats; optionally insert random gaps carrying junk data.
  task automatic load(input bit gaps);
    int n = 0;
    while (n < TAPS) begin
      chk("wr_en_idle", 64'(wr_en), 64'(0));
      chk("ready_load", 64'(coef_ready), 64'(1));
      if (gaps && ($urandom_range(1, 0) == 1)) begin
        coef_valid = 1'b0;
        coef_data  = CW'($urandom);
      end else begin
        coef_valid = 1'b1;
        coef_data  = cf[n][CW-1:0];
        n++;
      end
      @(posedge clk); #1;
    end
    coef_valid = 1'b0;
  endtask

  // Called #1 after the last-beat edge; checks writes, done and return to LOAD.
  task automatic check_build(input bit junk);
    int a;
    for (int c = 1; c <= N + 2; c++) begin
      if (junk && c < 100) begin
        coef_valid = 1'b1;
        coef_data  = CW'($urandom);
      end else begin
        coef_valid = 1'b0;
      end
      @(negedge clk);
      if (c <= N) begin
        a = (c - 1) ^ ((c - 1) >> 1);
        chk("wr_en", 64'(wr_en), 64'(1));
        chk("wr_addr", 64'(wr_addr), 64'(a));
        chk("wr_data", 64'(wr_data), 64'(ref_word(a)));
        chk("done_early", 64'(done), 64'(0));
        chk("ready_build", 64'(coef_ready), 64'(0));
      end else if (c == N + 1) begin
        chk("done", 64'(done), 64'(1));
        chk("wr_en_done", 64'(wr_en), 64'(0));
        chk("busy_done", 64'(busy), 64'(1));
        chk("ready_done", 64'(coef_ready), 64'(0));
`ifdef DA_LUT_CHECKSUM_EN
        chk("checksum", 64'(checksum), 64'(ref_csum()));
`endif
      end else begin
        chk("ready_back", 64'(coef_ready), 64'(1));
        chk("done_once", 64'(done), 64'(0));
        chk("busy_idle", 64'(busy), 64'(0));
        chk("wr_en_after", 64'(wr_en), 64'(0));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_wr_en"}, 64'(wr_en), 64'(0));
    chk({tag, "_wr_addr"}, 64'(wr_addr), 64'(0));
    chk({tag, "_wr_data"}, 64'(wr_data), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_done"}, 64'(done), 64'(0));
    chk({tag, "_ready"}, 64'(coef_ready), 64'(1));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_idle("rst");
    rst = 1'b0;
    @(posedge clk); #1;

    // All ones: word = popcount(addr)
    for (int j = 0; j < TAPS; j++) cf[j] = 1;
    load(1'b0); check_build(1'b0);

    // Most negative coef0 only
    for (int j = 0; j < TAPS; j++) cf[j] = 0;
    cf[0] = -2048;
    load(1'b0); check_build(1'b0);

    // All max positive
    for (int j = 0; j < TAPS; j++) cf[j] = 2047;
    load(1'b0); check_build(1'b0);

    // 1..7 with valid gaps and junk valid during the build
    for (int j = 0; j < TAPS; j++) cf[j] = j + 1;
    load(1'b1); check_build(1'b1);

    // Async reset at the 50th write, then full reload
    for (int j = 0; j < TAPS; j++) cf[j] = int'($urandom_range(4095)) - 2048;
    load(1'b0);
    repeat (50) @(negedge clk);
    chk("wr_en_50", 64'(wr_en), 64'(1));
    #1 rst = 1'b1;
    #1 chk_idle("midrst");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    for (int j = 0; j < TAPS; j++) cf[j] = j + 1;
    load(1'b0); check_build(1'b0);

    // All -1
    for (int j = 0; j < TAPS; j++) cf[j] = -1;
    load(1'b0); check_build(1'b0);

    // Random sets
    repeat (4) begin
      for (int j = 0; j < TAPS; j++) cf[j] = int'($urandom_range(4095)) - 2048;
      load(1'b1); check_build(1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/da_lut_builder.md
# da_lut_builder

Programs the 2^TAPS-entry partial-sum table used by the distributed-arithmetic FIR datapath. It accepts TAPS signed coefficients over a valid/ready stream and then writes every table word through a RAM-style write port, one word per clock. Words are generated in Gray-code address order, so each word needs a single add or subtract. It sits between the coefficient source (host/config register file) and the RAM-based LUT read by the DA filter, allowing filter reprogramming without resynthesis.

## Interface
- TAPS, 7, number of taps; table depth 2^TAPS; address bit j selects coefficient j (bit 0 = newest sample tap)
- CW, 12, signed coefficient width
- OW, 17, signed table word width; must satisfy OW >= CW + ceil(log2(TAPS)) (default: 12 + 3 = 15 < 17, no overflow possible)
- clk  in  1  clock; all logic rising-edge
- rst  in  1  asynchronous, active-high reset
- coef_valid  in  1  coefficient beat valid
- coef_ready  out  1  builder accepts a beat
- coef_data  in  CW  signed coefficient; beat n carries coefficient n (n = 0..TAPS-1)
- wr_en  out  1  table write strobe
- wr_addr  out  TAPS  table write address
- wr_data  out  OW  signed table word = sum of coef[j] over set bits j of wr_addr
- busy  out  1  high in BUILD and DONE
- done  out  1  one-cycle pulse after the final write
- checksum  out  24  (only with DA_LUT_CHECKSUM_EN) wrapping sum of all written words

## Operation
- Reset: all outputs 0 except coef_ready = 1. Coefficient registers, beat counter, Gray counter, accumulator and state all clear to 0/LOAD.
- States: LOAD -> BUILD -> DONE -> LOAD.
- LOAD: coef_ready = 1. A beat is accepted when coef_valid && coef_ready. It stores coef_data into coef[cnt], and cnt increments. Acceptance of beat TAPS-1 moves to BUILD and clears cnt, k and the accumulator.
- BUILD: coef_ready = 0, and coef_valid is ignored. Step counter k runs 0..2^TAPS-1. Address g = k ^ (k >> 1). Step 0 writes address 0 with data 0.
- Step k -> k+1: j = index of lowest set bit of k+1. The accumulator adds coef[j] (sign-extended to OW) if bit j of g(k+1) is 1, otherwise it subtracts coef[j].
- Write order for TAPS = 7: 0, 1, 3, 2, 6, 7, 5, 4, ... ending at address 64. Every address is written exactly once.
- Arithmetic: two's complement, full precision in OW bits, no saturation.
- DONE: one cycle. done = 1, wr_en = 0, then the block returns to LOAD with coef_ready = 1.
- Reset mid-operation (any state): the block returns to LOAD immediately. Partially written table contents are undefined, and the source must reload all TAPS beats.

## Timing
- wr_en, wr_addr and wr_data are registered outputs.
- The first write (address 0) is visible the cycle after the last coefficient is accepted.
- Writes are on consecutive cycles with no bubbles. wr_en is high for exactly 2^TAPS cycles.
- done is high the cycle after the last wr_en cycle. coef_ready returns the cycle after done.
- Load-to-done latency = 2^TAPS + 1 cycles after the last beat (129 for TAPS = 7).
- LOAD accepts one beat per cycle when coef_valid is held. Gaps in coef_valid only stall the count.

## Configuration
- DA_LUT_CHECKSUM_EN defined:
  - Adds a 24-bit checksum register. It clears on entry to BUILD and adds the sign-extended wr_data on every write.
  - The checksum is stable from the done cycle until the next BUILD entry.
  - Expected value = 2^(TAPS-1) × sum(coef), mod 2^24.
- DA_LUT_CHECKSUM_EN undefined: the checksum port and its logic are absent. All other behaviour is identical.

## Test plan
- All coefficients = 1, continuous valid -> 128 writes, wr_data = popcount(wr_addr). Addr 127 -> 7. Addr sequence starts 0, 1, 3, 2, 6. done at cycle 129 after the last beat.
- coef0 = -2048, others 0 -> odd addresses 17'h1F800 (-2048), even addresses 0. No wr_en outside the 128-cycle window.
- All coefficients = 2047 -> addr 127 = 14329, addr 64 = 2047. No overflow. Data is never negative.
- coef_valid toggled 1,0,0,1,... over 7 beats, with coef_data changing while valid = 0 -> only valid beats are stored. Output matches the reference sum for coefs 1..7. Addr 127 = 28.
- Assert rst at the 50th write -> all outputs 0 (coef_ready = 1) without waiting for a clock. After release, reload coefs 1..7 -> a full correct 128-word table and one done pulse.
- With DA_LUT_CHECKSUM_EN, coefs 1..7 -> checksum = 64 × 28 = 1792 at done. Coefs all -1 -> 24'hFFFE40.
